tx_link_ctrl: RTL and testbench
===============================

TX_LINK_CTRL -- requirements
Module: tx_link_ctrl

Interface
REQ-001 Parameter: ILAS_MF, default 4, number of ILAS multiframes sent per link-up (legal 1..4).
REQ-002 clk  input  1  device clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_frame_clk  input  1  frame-clock enable; one clk-wide pulse per frame.
REQ-005 i_lmfc  input  1  LMFC pulse; coincides with the i_frame_clk pulse of frame 0 of each multiframe.
REQ-006 i_K  input  5  frames per multiframe minus 1.
REQ-007 i_sync_request  input  1  link re-initialization request from the SYNC~ decoder.
REQ-008 i_sync_de_assertion  input  1  SYNC~ low-to-high detected, level.
REQ-009 i_err_reporting  input  1  SYNC~ error-report pulse/level from the SYNC~ decoder.
REQ-010 o_state  output  2  CGS=0, WAIT_LMFC=1, ILAS=2, DATA=3.
REQ-011 o_send_cgs / o_send_ilas / o_send_data  output  1 each  one-hot lane-mux select.
REQ-012 o_ilas_char  output  2  ILAS control-character select: 0=data/config, 1=/R/ K28.0, 2=/A/ K28.3, 3=/Q/ K28.4.
REQ-013 o_ilas_mf_cnt  output  2  current ILAS multiframe index.
REQ-014 o_frame_cnt  output  5  frame index within the current ILAS multiframe.
REQ-015 o_link_up  output  1  high while in DATA.
REQ-016 o_err_cnt  output  8  count of error reports received in DATA, saturating.

Function
REQ-017 The FSM SHALL be Moore; all outputs are registered and follow the state register with zero additional latency.
REQ-018 Transitions SHALL take effect on the clk edge after the condition is sampled, with one-cycle latency.
REQ-019 i_sync_request=1 SHALL force CGS from any state; this has top priority over all other transitions.
REQ-020 CGS -> WAIT_LMFC SHALL occur when i_sync_request=0 and i_sync_de_assertion=1.
REQ-021 WAIT_LMFC -> ILAS SHALL occur on i_lmfc=1; o_frame_cnt and o_ilas_mf_cnt load 0.
REQ-022 In ILAS, each i_frame_clk pulse SHALL increment o_frame_cnt; at o_frame_cnt==i_K it wraps to 0 and o_ilas_mf_cnt increments.
REQ-023 ILAS -> DATA SHALL occur on the i_frame_clk pulse where o_frame_cnt==i_K and o_ilas_mf_cnt==ILAS_MF-1.
REQ-024 o_ilas_char SHALL be /R/ (1) at frame 0 of each ILAS multiframe.
REQ-025 o_ilas_char SHALL be /A/ (2) at frame i_K of each ILAS multiframe.
REQ-026 o_ilas_char SHALL be /Q/ (3) at frame 1 of multiframe 1.
REQ-027 o_ilas_char SHALL be 0 otherwise and in all states other than ILAS.
REQ-028 When i_K==0, /A/ SHALL take precedence over /R/.
REQ-029 When i_K==1, /Q/ SHALL take precedence over /A/ at frame 1 of multiframe 1.
REQ-030 o_send_cgs SHALL be 1 in CGS and WAIT_LMFC, o_send_ilas 1 in ILAS, and o_send_data 1 in DATA; exactly one is high.
REQ-031 o_err_cnt SHALL increment by 1 on each 0->1 edge of i_err_reporting while in DATA, saturate at 255, and clear on entry to CGS.
REQ-032 i_K SHALL be sampled on entry to ILAS; a change of i_K mid-ILAS SHALL be ignored until the next ILAS.
REQ-033 Simultaneous i_sync_request and i_lmfc SHALL result in CGS.
REQ-034 i_frame_clk in CGS and DATA SHALL not alter the counters.

Reset
REQ-035 rst_n low SHALL asynchronously set o_state=CGS, o_send_cgs=1, o_send_ilas=0, o_send_data=0, o_ilas_char=0, o_ilas_mf_cnt=0, o_frame_cnt=0, o_link_up=0, o_err_cnt=0, and the internal error-edge register=0.
REQ-036 After release, the first transition SHALL require REQ-020 conditions; reset asserted mid-ILAS or mid-DATA SHALL return to CGS immediately.

Configuration
REQ-037 Macro TX_ILAS_BYPASS_EN: when defined, WAIT_LMFC SHALL go directly to DATA on i_lmfc and ILAS is unreachable; o_send_ilas and o_ilas_char stay 0.
REQ-038 When TX_ILAS_BYPASS_EN is undefined, the full CGS->WAIT_LMFC->ILAS->DATA sequence SHALL apply.

Verification
REQ-039 Bring-up: reset, i_sync_request=1 for 10 frames, then release with i_sync_de_assertion=1, i_K=3, frame_clk every 2 clk -> ILAS begins at the next i_lmfc; DATA reached after exactly 16 frames; o_link_up=1.
REQ-040 ILAS characters: i_K=3 -> per multiframe, frames 0..3 show /R/,0,0,/A/; multiframe 1 frames show /R/,/Q/,0,/A/.
REQ-041 Re-sync: assert i_sync_request during multiframe 2 of ILAS -> o_state=CGS next clk, counters=0, o_send_cgs=1.
REQ-042 Error count: in DATA, apply 300 i_err_reporting pulses -> o_err_cnt=255; then i_sync_request=1 -> o_err_cnt=0.
REQ-043 Boundary i_K=0: ILAS lasts 4 frames, each showing /A/; i_sync_request and i_lmfc asserted together in WAIT_LMFC -> CGS.
REQ-044 With TX_ILAS_BYPASS_EN defined: i_lmfc in WAIT_LMFC -> o_state=DATA next clk; o_send_ilas is never 1.

Source files
------------

// File: rtl/tx_link_ctrl.sv
// rtl/tx_link_ctrl.sv - JESD204-style TX link FSM: CGS -> WAIT_LMFC -> ILAS -> DATA.
// Define TX_ILAS_BYPASS_EN to skip ILAS and go from WAIT_LMFC straight to DATA.
module tx_link_ctrl #(
    parameter int ILAS_MF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame_clk,
    input  logic       i_lmfc,
    input  logic [4:0] i_K,
    input  logic       i_sync_request,
    input  logic       i_sync_de_assertion,
    input  logic       i_err_reporting,
    output logic [1:0] o_state,
    output logic       o_send_cgs,
    output logic       o_send_ilas,
    output logic       o_send_data,
    output logic [1:0] o_ilas_char,
    output logic [1:0] o_ilas_mf_cnt,
    output logic [4:0] o_frame_cnt,
    output logic       o_link_up,
    output logic [7:0] o_err_cnt
);

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } state_e;

    localparam logic [1:0] LAST_MF = 2'(ILAS_MF - 1);

    state_e     state_q, state_d;
    logic [4:0] frame_q, frame_d;
    logic [4:0] k_q, k_d;
    logic [1:0] mf_q, mf_d;
    logic [7:0] err_q, err_d;
    logic       err_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CGS;
            frame_q    <= 5'd0;
            k_q        <= 5'd0;
            mf_q       <= 2'd0;
            err_q      <= 8'd0;
            err_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            k_q        <= k_d;
            mf_q       <= mf_d;
            err_q      <= err_d;
            err_prev_q <= i_err_reporting;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        k_d     = k_q;
        mf_d    = mf_q;
        err_d   = err_q;
        unique case (state_q)
            ST_CGS: begin
                if (i_sync_de_assertion) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_lmfc) begin
                    frame_d = 5'd0;
                    mf_d    = 2'd0;
                    k_d     = i_K;
`ifdef TX_ILAS_BYPASS_EN
                    state_d = ST_DATA;
`else
                    state_d = ST_ILAS;
`endif
                end
            end
            ST_ILAS: begin
                // K is frozen in k_q for the whole ILAS sequence
                if (i_frame_clk) begin
                    if (frame_q == k_q) begin
                        frame_d = 5'd0;
                        if (mf_q == LAST_MF) begin
                            state_d = ST_DATA;
                            mf_d    = 2'd0;
                        end else begin
                            mf_d = mf_q + 2'd1;
                        end
                    end else begin
                        frame_d = frame_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (i_err_reporting && !err_prev_q && (err_q != 8'hFF))
                    err_d = err_q + 8'd1;
            end
            default: state_d = ST_CGS;
        endcase
        if (i_sync_request) begin
            state_d = ST_CGS;
            frame_d = 5'd0;
            mf_d    = 2'd0;
            err_d   = 8'd0;
        end
    end

    // /Q/ beats /A/ (K==1), /A/ beats /R/ (K==0)
    always_comb begin
        o_ilas_char = 2'd0;
        if (state_q == ST_ILAS) begin
            if ((mf_q == 2'd1) && (frame_q == 5'd1))
                o_ilas_char = 2'd3;
            else if (frame_q == k_q)
                o_ilas_char = 2'd2;
            else if (frame_q == 5'd0)
                o_ilas_char = 2'd1;
        end
    end

    assign o_state       = state_q;
    assign o_send_cgs    = (state_q == ST_CGS) || (state_q == ST_WAIT);
    assign o_send_ilas   = (state_q == ST_ILAS);
    assign o_send_data   = (state_q == ST_DATA);
    assign o_link_up     = (state_q == ST_DATA);
    assign o_ilas_mf_cnt = mf_q;
    assign o_frame_cnt   = frame_q;
    assign o_err_cnt     = err_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// tb/tb_tx_link_ctrl.sv - randomized bench for tx_link_ctrl against a frame-index reference model.
module tb_tx_link_ctrl;

    localparam int ILAS_MF = 4;
`ifdef TX_ILAS_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_frame_clk = 1'b0;
    logic       i_lmfc = 1'b0;
    logic [4:0] i_K = 5'd0;
    logic       i_sync_request = 1'b0;
    logic       i_sync_de_assertion = 1'b0;
    logic       i_err_reporting = 1'b0;
    logic [1:0] o_state;
    logic       o_send_cgs, o_send_ilas, o_send_data;
    logic [1:0] o_ilas_char;
    logic [1:0] o_ilas_mf_cnt;
    logic [4:0] o_frame_cnt;
    logic       o_link_up;
    logic [7:0] o_err_cnt;

    tx_link_ctrl #(.ILAS_MF(ILAS_MF)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_frame_clk         (i_frame_clk),
        .i_lmfc              (i_lmfc),
        .i_K                 (i_K),
        .i_sync_request      (i_sync_request),
        .i_sync_de_assertion (i_sync_de_assertion),
        .i_err_reporting     (i_err_reporting),
        .o_state             (o_state),
        .o_send_cgs          (o_send_cgs),
        .o_send_ilas         (o_send_ilas),
        .o_send_data         (o_send_data),
        .o_ilas_char         (o_ilas_char),
        .o_ilas_mf_cnt       (o_ilas_mf_cnt),
        .o_frame_cnt         (o_frame_cnt),
        .o_link_up           (o_link_up),
        .o_err_cnt           (o_err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // stimulus knobs
    int   fp = 2, fdiv = 0, fnum = 0;
    int   k_in = 3;
    logic sync_req_v = 1'b0, de_v = 1'b0, err_v = 1'b0;
    bit   sreq_on_lmfc = 0;
    int   ilas_pulses = 0;
    int   seen_ilas = 0;

    // reference model: ILAS tracked as a flat frame index since ILAS start
    int m_state = 0, m_idx = 0, m_k = 0, m_err = 0, m_err_prev = 0;

    task automatic model_update(input bit fc, input bit lm, input bit sr, input bit de, input bit er);
        if (!rst_n) begin
            m_state = 0; m_idx = 0; m_err = 0; m_err_prev = 0;
        end else begin
            if (sr) begin
                m_state = 0; m_idx = 0; m_err = 0;
            end else begin
                case (m_state)
                    0: if (de) m_state = 1;
                    1: if (lm) begin m_idx = 0; m_k = k_in; m_state = BYP ? 3 : 2; end
                    2: if (fc) begin
                        m_idx++;
                        if (m_idx == ILAS_MF * (m_k + 1)) begin m_state = 3; m_idx = 0; end
                    end
                    default: if (er && m_err_prev == 0 && m_err < 255) m_err++;
                endcase
            end
            m_err_prev = er;
        end
    endtask

    task automatic check_outputs();
        int f, mf, ch;
        f = 0; mf = 0; ch = 0;
        if (m_state == 2) begin
            f  = m_idx % (m_k + 1);
            mf = m_idx / (m_k + 1);
            if (mf == 1 && f == 1) ch = 3;
            else if (f == m_k)     ch = 2;
            else if (f == 0)       ch = 1;
        end
        chk("state",     o_state, m_state);
        chk("send_cgs",  o_send_cgs, (m_state <= 1) ? 1 : 0);
        chk("send_ilas", o_send_ilas, (m_state == 2) ? 1 : 0);
        chk("send_data", o_send_data, (m_state == 3) ? 1 : 0);
        chk("link_up",   o_link_up, (m_state == 3) ? 1 : 0);
        chk("frame_cnt", o_frame_cnt, f);
        chk("mf_cnt",    o_ilas_mf_cnt, mf);
        chk("ilas_char", o_ilas_char, ch);
        chk("err_cnt",   o_err_cnt, m_err);
    endtask

    task automatic step();
        bit fc, lm, sr;
        fc = (fdiv == 0);
        lm = fc && (fnum == 0);
        sr = sync_req_v || (sreq_on_lmfc && lm);
        i_frame_clk = fc; i_lmfc = lm; i_sync_request = sr;
        i_sync_de_assertion = de_v; i_err_reporting = err_v; i_K = 5'(k_in);
        if (o_state == 2'd2 && fc && !sr) ilas_pulses++;
        if (o_send_ilas) seen_ilas = 1;
        @(posedge clk);
        model_update(fc, lm, sr, de_v, err_v);
        fdiv = (fdiv + 1 >= fp) ? 0 : fdiv + 1;
        if (fc) fnum = (fnum >= k_in) ? 0 : fnum + 1;
        #1;
        check_outputs();
    endtask

    task automatic run_until(input int st, input int budget, input string tag);
        int n;
        n = 0;
        while (m_state != st && n < budget) begin step(); n++; end
        if (m_state != st) chk(tag, m_state, st);
    endtask

    task automatic resync();
        sync_req_v = 1'b1; step(); sync_req_v = 1'b0;
    endtask

    initial begin
        // reset
        repeat (3) step();
        rst_n = 1'b1;

        // bring-up: K=3, frame every 2 clk
        k_in = 3; fp = 2; fdiv = 0; fnum = 0;
        sync_req_v = 1'b1;
        repeat (20) step();
        sync_req_v = 1'b0; de_v = 1'b1; ilas_pulses = 0;
        run_until(3, 400, "bringup_timeout");
        chk("bringup_ilas_frames", ilas_pulses, BYP ? 0 : ILAS_MF * 4);
        chk("bringup_link_up", o_link_up, 1);

        // error-count saturation and clear
        repeat (300) begin err_v = 1'b1; step(); err_v = 1'b0; step(); end
        chk("err_saturated", o_err_cnt, 255);
        resync();
        chk("err_cleared", o_err_cnt, 0);

`ifndef TX_ILAS_BYPASS_EN
        // re-sync during multiframe 2
        k_in = 2;
        run_until(2, 400, "resync_ilas_timeout");
        begin
            int n;
            n = 0;
            while (m_idx / (m_k + 1) != 2 && n < 200) begin step(); n++; end
            chk("reached_mf2", o_ilas_mf_cnt, 2);
        end
        resync();
        chk("resync_state", o_state, 0);
        chk("resync_frame", o_frame_cnt, 0);
        chk("resync_mf", o_ilas_mf_cnt, 0);
        chk("resync_send_cgs", o_send_cgs, 1);
`endif

        // K=0 boundary
        k_in = 0; resync(); ilas_pulses = 0;
        run_until(3, 400, "k0_timeout");
        chk("k0_ilas_frames", ilas_pulses, BYP ? 0 : ILAS_MF);

        // sync request coinciding with LMFC while in WAIT_LMFC
        resync(); de_v = 1'b1; step(); de_v = 1'b0;
        chk("in_wait", o_state, 1);
        sreq_on_lmfc = 1;
        begin
            int n;
            n = 0;
            while (m_state == 1 && n < 50) begin step(); n++; end
        end
        sreq_on_lmfc = 0;
        chk("sync_lmfc_cgs", o_state, 0);

        // async reset while sequencing
        k_in = 5; de_v = 1'b1;
        run_until(BYP ? 3 : 2, 400, "rst_timeout");
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", o_state, 0);
        chk("async_rst_frame", o_frame_cnt, 0);
        chk("async_rst_mf", o_ilas_mf_cnt, 0);
        chk("async_rst_send_cgs", o_send_cgs, 1);
        repeat (2) step();
        rst_n = 1'b1;
        de_v = 1'b0;
        repeat (5) step();

        // randomized traffic
        k_in = 1;
        for (int i = 0; i < 6000; i++) begin
            sync_req_v = ($urandom_range(0, 599) == 0);
            de_v       = ($urandom_range(0, 3) != 0);
            err_v      = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 249) == 0) k_in = $urandom_range(0, 7);
            if ($urandom_range(0, 249) == 0) fp = $urandom_range(1, 3);
            step();
        end

`ifdef TX_ILAS_BYPASS_EN
        chk("never_send_ilas", seen_ilas, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
